// File: rtl/alu_pkg.sv
// Shared constants for the ALU issuer: opcodes, FSM encodings and default width.
package alu_pkg;

  localparam int unsigned DEFAULT_DATA_W = 32;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_OR  = 2'd2;
  localparam logic [1:0] OP_AND = 2'd3;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

endpackage

// File: rtl/alu_ref_model.sv
// Combinational golden model of the ALU; used to cross-check captured results.
module alu_ref_model
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [1:0]        i_op,
  output logic [DATA_W-1:0] o_result
);

  // Expected result; ADD/SUB wrap naturally at DATA_W bits.
  always_comb begin
    o_result = '0;
    unique case (i_op)
      OP_ADD:  o_result = i_a + i_b;
      OP_SUB:  o_result = i_a - i_b;
      OP_OR:   o_result = i_a | i_b;
      OP_AND:  o_result = i_a & i_b;
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/alu_issuer.sv
// Initiator for a registered ALU: accepts commands, drives operands/enable for ALU_LAT
// cycles, captures the result and returns it with the command tag.
// Optional result cross-check and error counter: define ALU_ISSUER_CHECK_EN.
module alu_issuer
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W  = DEFAULT_DATA_W,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic [1:0]        cmd_op,
  input  logic [TAG_W-1:0]  cmd_tag,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [1:0]        alu_op,
  output logic              alu_en,
  input  logic [DATA_W-1:0] alu_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              rsp_err,
  output logic              busy
`ifdef ALU_ISSUER_CHECK_EN
  ,
  output logic [7:0]        err_cnt
`endif
);

  localparam int unsigned CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALU_LAT - 1);

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_alu_a;
  logic [DATA_W-1:0] r_alu_b;
  logic [1:0]        r_alu_op;
  logic [TAG_W-1:0]  r_tag;
  logic [DATA_W-1:0] r_rsp_data;
  logic              w_cmd_ready;
  logic              w_accept;

  // Gated by rst_n so ready stays low while reset is held.
  assign w_cmd_ready = rst_n && ((r_state == S_IDLE) || ((r_state == S_DONE) && rsp_ready));
  assign w_accept    = cmd_valid && w_cmd_ready;

  // Next-state decode; a DONE handshake with a new command goes straight back to ISSUE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_state_nxt = S_ISSUE;
      S_ISSUE:   if (r_cnt == CNT_LAST) w_state_nxt = S_CAPTURE;
      S_CAPTURE: w_state_nxt = S_DONE;
      S_DONE:    if (rsp_ready) w_state_nxt = w_accept ? S_ISSUE : S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // State and enable-cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == S_ISSUE) && (w_state_nxt == S_ISSUE)) r_cnt <= r_cnt + CNT_W'(1);
      else r_cnt <= '0;
    end
  end

  // Operand/tag latch: only moves on an accepted command, so it is stable while alu_en=1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_a  <= '0;
      r_alu_b  <= '0;
      r_alu_op <= OP_ADD;
      r_tag    <= '0;
    end else if (w_accept) begin
      r_alu_a  <= cmd_a;
      r_alu_b  <= cmd_b;
      r_alu_op <= cmd_op;
      r_tag    <= cmd_tag;
    end
  end

  // Result capture one cycle after the last enable cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rsp_data <= '0;
    else if (r_state == S_CAPTURE) r_rsp_data <= alu_result;
  end

`ifdef ALU_ISSUER_CHECK_EN
  logic [DATA_W-1:0] w_expected;
  logic              w_mismatch;
  logic              r_rsp_err;
  logic [7:0]        r_err_cnt;

  alu_ref_model #(
    .DATA_W(DATA_W)
  ) u_ref_model (
    .i_a      (r_alu_a),
    .i_b      (r_alu_b),
    .i_op     (r_alu_op),
    .o_result (w_expected)
  );

  assign w_mismatch = (alu_result != w_expected);

  // Error flag travels with the response; counter saturates at 255.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_err <= 1'b0;
      r_err_cnt <= '0;
    end else if (r_state == S_CAPTURE) begin
      r_rsp_err <= w_mismatch;
      if (w_mismatch && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign rsp_err = r_rsp_err;
  assign err_cnt = r_err_cnt;
`else
  assign rsp_err = 1'b0;
`endif

  assign cmd_ready = w_cmd_ready;
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_op    = r_alu_op;
  assign alu_en    = (r_state == S_ISSUE);
  assign rsp_valid = (r_state == S_DONE);
  assign rsp_data  = r_rsp_data;
  assign rsp_tag   = r_tag;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_issuer.sv
// Directed bench for alu_issuer driving a simple one-cycle registered ALU.
module tb_alu_issuer;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic [1:0]  cmd_op;
  logic [3:0]  cmd_tag;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [1:0]  alu_op;
  logic        alu_en;
  logic [31:0] alu_result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [3:0]  rsp_tag;
  logic        rsp_err;
  logic        busy;
`ifdef ALU_ISSUER_CHECK_EN
  logic [7:0]  err_cnt;
`endif

  logic [31:0] alu_q;
  logic        force_zero;
  int          checks;
  int          errors;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic [3:0]  tag;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [8];

  alu_issuer #(
    .DATA_W  (32),
    .TAG_W   (4),
    .ALU_LAT (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_op     (cmd_op),
    .cmd_tag    (cmd_tag),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_en     (alu_en),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_tag    (rsp_tag),
    .rsp_err    (rsp_err),
    .busy       (busy)
`ifdef ALU_ISSUER_CHECK_EN
    ,
    .err_cnt    (err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered ALU: result valid one edge after en.
  always_ff @(posedge clk) begin
    if (alu_en) begin
      case (alu_op)
        2'd0:    alu_q <= alu_a + alu_b;
        2'd1:    alu_q <= alu_a - alu_b;
        2'd2:    alu_q <= alu_a | alu_b;
        default: alu_q <= alu_a & alu_b;
      endcase
    end
  end

  assign alu_result = force_zero ? 32'd0 : alu_q;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // One full transaction with rsp_ready=1; accept edge counts as the first of the three.
  task automatic run_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] op, input logic [3:0] tag,
                        input logic [31:0] exp_d, input logic exp_e);
    int lat;
    int en_cyc;
    int guard;
    int moved;
    @(negedge clk);
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_tag = tag; cmd_valid = 1'b1; rsp_ready = 1'b1;
    guard = 0;
    while (!cmd_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk({nm, "_ready"}, {31'd0, cmd_ready}, 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    chk({nm, "_alu_a"}, alu_a, a);
    chk({nm, "_alu_b"}, alu_b, b);
    chk({nm, "_alu_op"}, {30'd0, alu_op}, {30'd0, op});
    lat = 0; en_cyc = 0; moved = 0;
    while (!rsp_valid && lat < 20) begin
      if (alu_en) en_cyc++;
      if (alu_en && (alu_a !== a || alu_b !== b)) moved++;
      @(posedge clk);
      #1;
      lat++;
    end
    chk({nm, "_latency"}, 32'(lat), 32'd2);
    chk({nm, "_en_cycles"}, 32'(en_cyc), 32'd1);
    chk({nm, "_operand_moved"}, 32'(moved), 32'd0);
    chk({nm, "_data"}, rsp_data, exp_d);
    chk({nm, "_tag"}, {28'd0, rsp_tag}, {28'd0, tag});
    chk({nm, "_err"}, {31'd0, rsp_err}, {31'd0, exp_e});
    @(posedge clk);
    #1;
    chk({nm, "_rsp_done"}, {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    int seen;
    checks = 0; errors = 0;
    force_zero = 1'b0;
    cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0; cmd_tag = '0; rsp_ready = 1'b0;

    vecs[0] = '{"add",      32'd19260817,   32'd99999999,   2'd0, 4'd3,  32'd119260816};
    // 100 - 99999999 = 2^32 - 99999899
    vecs[1] = '{"sub_wrap", 32'd100,        32'd99999999,   2'd1, 4'd5,  32'd4194967397};
    vecs[2] = '{"or",       32'h0000F0F0,   32'h00000F0F,   2'd2, 4'd6,  32'h0000FFFF};
    vecs[3] = '{"and",      32'h0000FF00,   32'h00000FF0,   2'd3, 4'd7,  32'h00000F00};
    vecs[4] = '{"add_wrap", 32'hFFFFFFFF,   32'h00000001,   2'd0, 4'd15, 32'h00000000};
    vecs[5] = '{"sub_neg",  32'h00000000,   32'h00000001,   2'd1, 4'd0,  32'hFFFFFFFF};
    vecs[6] = '{"and_mask", 32'hA5A5A5A5,   32'hFFFF0000,   2'd3, 4'd10, 32'hA5A50000};
    vecs[7] = '{"or_msb",   32'h80000000,   32'h00000001,   2'd2, 4'd12, 32'h80000001};

    // Reset state
    rst_n = 1'b0;
    #12;
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_alu_en",    {31'd0, alu_en},    32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_busy",      {31'd0, busy},      32'd0);
    chk("rst_alu_a",     alu_a,              32'd0);
    chk("rst_alu_b",     alu_b,              32'd0);
    chk("rst_rsp_data",  rsp_data,           32'd0);
    chk("rst_rsp_tag",   {28'd0, rsp_tag},   32'd0);
    chk("rst_rsp_err",   {31'd0, rsp_err},   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", {31'd0, cmd_ready}, 32'd1);

    // Table-driven single transactions
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].tag, vecs[i].exp_data, 1'b0);
    end

    // Backpressure: response held, new command ignored while stalled
    @(negedge clk);
    cmd_a = 32'd5; cmd_b = 32'd7; cmd_op = 2'd0; cmd_tag = 4'd9;
    cmd_valid = 1'b1; rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    cmd_a = 32'hDEAD; cmd_b = 32'hBEEF; cmd_op = 2'd1; cmd_tag = 4'd1;
    guard = 0;
    while (!rsp_valid && guard < 20) begin
      @(posedge clk);
      #1;
      guard++;
    end
    chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      chk("bp_data",      rsp_data,             32'd12);
      chk("bp_tag",       {28'd0, rsp_tag},     32'd9);
      chk("bp_cmd_ready", {31'd0, cmd_ready},   32'd0);
      chk("bp_alu_en",    {31'd0, alu_en},      32'd0);
      chk("bp_alu_a",     alu_a,                32'd5);
      chk("bp_valid_hold",{31'd0, rsp_valid},   32'd1);
    end
    @(negedge clk);
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    #1;
    chk("bp_ready_on_release", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk);
    #1;
    chk("bp_complete", {31'd0, rsp_valid}, 32'd0);
    chk("bp_idle",     {31'd0, busy},      32'd0);

    // Back-to-back: second command accepted on the edge the first response completes
    @(negedge clk);
    cmd_a = 32'hF0F0; cmd_b = 32'h0F0F; cmd_op = 2'd2; cmd_tag = 4'd1;
    cmd_valid = 1'b1; rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    cmd_a = 32'hFF00; cmd_b = 32'h0FF0; cmd_op = 2'd3; cmd_tag = 4'd2;
    @(posedge clk);
    #1;
    chk("b2b_no_accept_capture", alu_a, 32'hF0F0);
    @(posedge clk);
    #1;
    chk("b2b_first_valid", {31'd0, rsp_valid}, 32'd1);
    chk("b2b_first_data",  rsp_data,           32'h0000FFFF);
    chk("b2b_first_tag",   {28'd0, rsp_tag},   32'd1);
    chk("b2b_ready",       {31'd0, cmd_ready}, 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    chk("b2b_second_issue", {31'd0, alu_en},    32'd1);
    chk("b2b_second_a",     alu_a,              32'hFF00);
    chk("b2b_gap_valid",    {31'd0, rsp_valid}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("b2b_second_valid", {31'd0, rsp_valid}, 32'd1);
    chk("b2b_second_data",  rsp_data,           32'h00000F00);
    chk("b2b_second_tag",   {28'd0, rsp_tag},   32'd2);
    @(posedge clk);
    #1;
    chk("b2b_done", {31'd0, busy}, 32'd0);

    // Reset during ISSUE
    @(negedge clk);
    cmd_a = 32'd2; cmd_b = 32'd3; cmd_op = 2'd0; cmd_tag = 4'd4; cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    chk("rmid_in_issue", {31'd0, alu_en}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rmid_alu_en",    {31'd0, alu_en},    32'd0);
    chk("rmid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rmid_busy",      {31'd0, busy},      32'd0);
    chk("rmid_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rmid_ready_after", {31'd0, cmd_ready}, 32'd1);
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      if (rsp_valid || busy) seen++;
    end
    chk("rmid_no_stale", 32'(seen), 32'd0);

`ifdef ALU_ISSUER_CHECK_EN
    // Forced ALU mismatches drive rsp_err and the saturating counter
    force_zero = 1'b1;
    run_op("chk_first", 32'd1, 32'd1, 2'd0, 4'd8, 32'd0, 1'b1);
    chk("err_cnt_one", {24'd0, err_cnt}, 32'd1);
    for (int k = 0; k < 300; k++) begin
      run_op("chk_many", 32'd1, 32'd1, 2'd0, 4'd8, 32'd0, 1'b1);
    end
    chk("err_cnt_sat", {24'd0, err_cnt}, 32'd255);
    force_zero = 1'b0;
    run_op("chk_clean", 32'd1, 32'd1, 2'd0, 4'd8, 32'd2, 1'b0);
    chk("err_cnt_hold", {24'd0, err_cnt}, 32'd255);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
